// File: rtl/onehot_pkg.sv
// Shared types and constants for the LED index sequencer.
// Holds the step-mode enum and the next-index/direction function.
package onehot_pkg;

    localparam int unsigned IDX_W          = 3;
    localparam logic [2:0]  IDX_MAX        = 3'd7;
    localparam int unsigned PRESCALE_W_DEF = 24;
    localparam int unsigned BASE_SHIFT_DEF = 14;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    // Returns {dir, idx} after one applied step.
    function automatic logic [IDX_W:0] next_state(input mode_e mode,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic dir);
        logic [IDX_W-1:0] nidx;
        logic             ndir;
        nidx = idx;
        ndir = dir;
        unique case (mode)
            MODE_HOLD: ;
            MODE_UP: begin
                nidx = idx + 3'd1;
                ndir = 1'b1;
            end
            MODE_DOWN: begin
                nidx = idx - 3'd1;
                ndir = 1'b0;
            end
            MODE_BOUNCE: begin
                // Reflect at the ends so an end value is never shown twice.
                if (dir) begin
                    if (idx == IDX_MAX) begin
                        nidx = IDX_MAX - 3'd1;
                        ndir = 1'b0;
                    end else begin
                        nidx = idx + 3'd1;
                    end
                end else begin
                    if (idx == '0) begin
                        nidx = 3'd1;
                        ndir = 1'b1;
                    end else begin
                        nidx = idx - 3'd1;
                    end
                end
            end
            default: ;
        endcase
        return {ndir, nidx};
    endfunction

endpackage

// File: rtl/onehot_prescaler.sv
// Programmable prescaler: ticks every 2^(BASE_SHIFT+rate_sel) enabled cycles.
module onehot_prescaler #(
    parameter int unsigned PRESCALE_W = onehot_pkg::PRESCALE_W_DEF,
    parameter int unsigned BASE_SHIFT = onehot_pkg::BASE_SHIFT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] rate_sel,
    input  logic       clear,
    output logic       tick
);

    logic [PRESCALE_W-1:0] count_q;
    logic [PRESCALE_W-1:0] count_d;
    logic [PRESCALE_W-1:0] term;
    logic [PRESCALE_W-1:0] one;

    assign one = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    // >= so a lowered rate_sel mid-count ticks at once instead of wrapping.
    always_comb begin
        term    = (one << (BASE_SHIFT + {29'd0, rate_sel})) - one;
        tick    = ena & (count_q >= term);
        count_d = count_q;
        if (ena) begin
            if (clear || tick) begin
                count_d = '0;
            end else begin
                count_d = count_q + one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/onehot_index_sequencer.sv
// Generates the 3-bit index for the one-hot LED decoder (hold/up/down/bounce).
// Optional manual step button enabled by ONEHOT_SEQ_MANUAL_STEP_EN.
module onehot_index_sequencer #(
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned PRESCALE_W = onehot_pkg::PRESCALE_W_DEF,
    parameter int unsigned BASE_SHIFT = onehot_pkg::BASE_SHIFT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [1:0]       mode_i,
    input  logic [2:0]       rate_sel_i,
    input  logic             load_i,
    input  logic [IDX_W-1:0] load_val_i,
`ifdef ONEHOT_SEQ_MANUAL_STEP_EN
    input  logic             step_btn_i,
`endif
    output logic [IDX_W-1:0] idx_o,
    output logic             dir_o,
    output logic             step_o
);

    import onehot_pkg::*;

    logic             tick;
    logic             do_load;
    logic             advance;
    logic             btn_edge;
    mode_e            eff_mode;
    logic [IDX_W:0]   nxt;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;

    onehot_prescaler #(
        .PRESCALE_W (PRESCALE_W),
        .BASE_SHIFT (BASE_SHIFT)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .rate_sel (rate_sel_i),
        .clear    (do_load),
        .tick     (tick)
    );

`ifdef ONEHOT_SEQ_MANUAL_STEP_EN
    logic [1:0] btn_sync_q;
    logic       btn_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync_q <= '0;
            btn_prev_q <= 1'b0;
        end else begin
            btn_sync_q <= {btn_sync_q[0], step_btn_i};
            btn_prev_q <= btn_sync_q[1];
        end
    end

    assign btn_edge = btn_sync_q[1] & ~btn_prev_q;
`else
    assign btn_edge = 1'b0;
`endif

    // A button edge in hold mode advances as up; a coincident tick is merged.
    always_comb begin
        do_load  = ena & load_i;
        advance  = ena & ~load_i & (tick | btn_edge);
        eff_mode = (btn_edge && mode_e'(mode_i) == MODE_HOLD) ? MODE_UP : mode_e'(mode_i);
        nxt      = next_state(eff_mode, idx_q, dir_q);
        idx_d    = idx_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        if (do_load) begin
            idx_d = load_val_i;
        end else if (advance) begin
            idx_d  = nxt[IDX_W-1:0];
            dir_d  = nxt[IDX_W];
            step_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            dir_q  <= 1'b1;
            step_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            dir_q  <= dir_d;
            step_q <= step_d;
        end
    end

    assign idx_o  = idx_q;
    assign dir_o  = dir_q;
    assign step_o = step_q;

endmodule

// File: tb/tb_onehot_index_sequencer.sv
// Directed scoreboard bench for onehot_index_sequencer with BASE_SHIFT=2.
module tb_onehot_index_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [1:0] mode_i;
    logic [2:0] rate_sel_i;
    logic       load_i;
    logic [2:0] load_val_i;
    logic       step_btn_i;
    logic [2:0] idx_o;
    logic       dir_o;
    logic       step_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] idx;
        logic       dir;
        int         gap;
    } exp_t;

    exp_t sb[$];

    onehot_index_sequencer #(
        .IDX_W      (3),
        .PRESCALE_W (12),
        .BASE_SHIFT (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .mode_i     (mode_i),
        .rate_sel_i (rate_sel_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
`ifdef ONEHOT_SEQ_MANUAL_STEP_EN
        .step_btn_i (step_btn_i),
`endif
        .idx_o      (idx_o),
        .dir_o      (dir_o),
        .step_o     (step_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_step(input logic [2:0] idx, input logic dir, input int gap);
        exp_t e;
        e.idx = idx;
        e.dir = dir;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // Waits (bounded) for the next step_o pulse and checks it against the queue head.
    task automatic wait_step(input string tag);
        exp_t e;
        int   n;
        bit   seen;
        e    = sb.pop_front();
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (step_o === 1'b1) seen = 1'b1;
        end
        chk($sformatf("%s.seen", tag), int'(seen), 1);
        chk($sformatf("%s.gap", tag), n, e.gap);
        chk($sformatf("%s.idx", tag), int'(idx_o), int'(e.idx));
        chk($sformatf("%s.dir", tag), int'(dir_o), int'(e.dir));
    endtask

    // Runs n cycles and checks that no step fires and idx stays put.
    task automatic quiet(input string tag, input int n, input logic [2:0] idx);
        int steps;
        steps = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (step_o !== 1'b0) steps++;
        end
        chk($sformatf("%s.steps", tag), steps, 0);
        chk($sformatf("%s.idx", tag), int'(idx_o), int'(idx));
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        mode_i     = 2'b01;
        rate_sel_i = 3'd0;
        load_i     = 1'b0;
        load_val_i = 3'd0;
        step_btn_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.idx", int'(idx_o), 0);
        chk("rst.dir", int'(dir_o), 1);
        chk("rst.step", int'(step_o), 0);

        // Up count with wrap 7 -> 0.
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            expect_step(3'(i % 8), 1'b1, 4);
            wait_step($sformatf("up%0d", i));
        end

        // Bounce starting from a loaded 5.
        mode_i     = 2'b11;
        load_i     = 1'b1;
        load_val_i = 3'd5;
        @(negedge clk);
        load_i = 1'b0;
        chk("bload.idx", int'(idx_o), 5);
        chk("bload.dir", int'(dir_o), 1);
        chk("bload.step", int'(step_o), 0);
        expect_step(3'd6, 1'b1, 4);
        expect_step(3'd7, 1'b1, 4);
        expect_step(3'd6, 1'b0, 4);
        expect_step(3'd5, 1'b0, 4);
        expect_step(3'd4, 1'b0, 4);
        expect_step(3'd3, 1'b0, 4);
        expect_step(3'd2, 1'b0, 4);
        expect_step(3'd1, 1'b0, 4);
        expect_step(3'd0, 1'b0, 4);
        expect_step(3'd1, 1'b1, 4);
        for (int i = 0; i < 10; i++) wait_step($sformatf("bounce%0d", i));

        // Down from 0 wraps to 7.
        mode_i     = 2'b10;
        load_i     = 1'b1;
        load_val_i = 3'd0;
        @(negedge clk);
        load_i = 1'b0;
        chk("dload.idx", int'(idx_o), 0);
        expect_step(3'd7, 1'b0, 4);
        wait_step("down");

        // Hold still pulses step_o.
        mode_i     = 2'b00;
        load_i     = 1'b1;
        load_val_i = 3'd3;
        @(negedge clk);
        load_i = 1'b0;
        expect_step(3'd3, 1'b0, 4);
        expect_step(3'd3, 1'b0, 4);
        wait_step("hold0");
        wait_step("hold1");

        // Load coincident with a tick: tick dropped, full period restarts.
        mode_i = 2'b01;
        repeat (3) @(negedge clk);
        load_i     = 1'b1;
        load_val_i = 3'd2;
        @(negedge clk);
        load_i = 1'b0;
        chk("ltick.idx", int'(idx_o), 2);
        chk("ltick.step", int'(step_o), 0);
        expect_step(3'd3, 1'b1, 4);
        wait_step("ltick.next");

        // Load with ena low is ignored.
        ena        = 1'b0;
        load_i     = 1'b1;
        load_val_i = 3'd6;
        quiet("loadoff", 5, 3'd3);
        load_i = 1'b0;
        ena    = 1'b1;
        expect_step(3'd4, 1'b1, 4);
        wait_step("loadoff.resume");

        // Freeze mid-period: remaining count is kept.
        repeat (2) @(negedge clk);
        ena = 1'b0;
        quiet("freeze", 10, 3'd4);
        ena = 1'b1;
        expect_step(3'd5, 1'b1, 2);
        wait_step("freeze.resume");

        // Lowering rate_sel with count at 20 ticks on the next cycle.
        rate_sel_i = 3'd3;
        quiet("slow", 20, 3'd5);
        rate_sel_i = 3'd0;
        expect_step(3'd6, 1'b1, 1);
        wait_step("ratedrop");

        // Async reset mid-bounce at idx=4, dir=0.
        mode_i = 2'b10;
        expect_step(3'd5, 1'b0, 4);
        wait_step("predown");
        mode_i = 2'b11;
        expect_step(3'd4, 1'b0, 4);
        wait_step("prebounce");
        #2 rst_n = 1'b0;
        #1;
        chk("arst.idx", int'(idx_o), 0);
        chk("arst.dir", int'(dir_o), 1);
        chk("arst.step", int'(step_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_step(3'd1, 1'b1, 4);
        wait_step("arst.resume");

`ifdef ONEHOT_SEQ_MANUAL_STEP_EN
        // Button in hold advances as up after sync latency.
        mode_i     = 2'b00;
        rate_sel_i = 3'd3;
        step_btn_i = 1'b1;
        expect_step(3'd2, 1'b1, 3);
        wait_step("btn.hold");
        step_btn_i = 1'b0;
        mode_i     = 2'b01;
        rate_sel_i = 3'd0;
        expect_step(3'd3, 1'b1, 1);
        wait_step("btn.realign");
        @(negedge clk);
        step_btn_i = 1'b1;
        expect_step(3'd4, 1'b1, 3);
        expect_step(3'd5, 1'b1, 4);
        wait_step("btn.coincide");
        wait_step("btn.after");
        step_btn_i = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
